// File: rtl/fwd_apply_ctrl_if.sv
// ============================================================================
// Module  : fwd_apply_ctrl_if
// Brief   : Bundle between the forwarding unit / stage registers and
//           fwd_apply_ctrl (operand select, hazard controls, WB_temp).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fwd_apply_ctrl_if #(
    parameter int XLEN  = 64,
    parameter int DEC_W = 22
);
    logic             stall;
    logic             temp_wb;
    logic [2:0]       forward_signal1;
    logic [2:0]       forward_signal2;
    logic             branch_taken;
    logic             mem_ready;
    logic [XLEN-1:0]  rs1_rf;
    logic [XLEN-1:0]  rs2_rf;
    logic [XLEN-1:0]  mem_alu;
    logic [XLEN-1:0]  wb_alu;
    logic [XLEN-1:0]  wb_load;
    logic [31:0]      WB_ins;
    logic [DEC_W-1:0] WB_decode;

    logic [XLEN-1:0]  rs1_fwd;
    logic [XLEN-1:0]  rs2_fwd;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_bubble;
    logic [31:0]      WB_temp_ins;
    logic [DEC_W-1:0] WB_temp_decode;
    logic [31:0]      stall_cnt;
    logic [31:0]      temp_hit_cnt;
    logic             fwd_err;

    modport master (
        output stall, temp_wb, forward_signal1, forward_signal2, branch_taken,
               mem_ready, rs1_rf, rs2_rf, mem_alu, wb_alu, wb_load, WB_ins,
               WB_decode,
        input  rs1_fwd, rs2_fwd, pc_en, if_id_en, id_ex_en, ex_mem_en,
               mem_wb_en, if_id_flush, id_ex_flush, ex_mem_bubble,
               WB_temp_ins, WB_temp_decode, stall_cnt, temp_hit_cnt, fwd_err
    );

    modport slave (
        input  stall, temp_wb, forward_signal1, forward_signal2, branch_taken,
               mem_ready, rs1_rf, rs2_rf, mem_alu, wb_alu, wb_load, WB_ins,
               WB_decode,
        output rs1_fwd, rs2_fwd, pc_en, if_id_en, id_ex_en, ex_mem_en,
               mem_wb_en, if_id_flush, id_ex_flush, ex_mem_bubble,
               WB_temp_ins, WB_temp_decode, stall_cnt, temp_hit_cnt, fwd_err
    );
endinterface

`default_nettype wire

// File: rtl/fwd_apply_ctrl.sv
// ============================================================================
// Module  : fwd_apply_ctrl
// Brief   : Builds EX operands from bypass selects, sequences stage enables /
//           flushes / bubbles, and keeps the WB_temp shadow stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_apply_ctrl #(
    parameter int          XLEN    = 64,
    parameter int          DEC_W   = 22,
    parameter logic [31:0] NOP_INS = 32'h00000013
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    fwd_apply_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_MWAIT  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_wait_stall;
    logic [XLEN-1:0]  r_tmp_alu;
    logic [XLEN-1:0]  r_tmp_load;
    logic [31:0]      r_temp_ins;
    logic [DEC_W-1:0] r_temp_dec;
    logic [31:0]      r_stall_cnt;
    logic [31:0]      r_hit_cnt;
    logic             r_fwd_err;

    logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
    logic w_if_id_flush, w_id_ex_flush, w_ex_mem_bubble;
    logic w_stall_now, w_prev_stall, w_sel_err;
    state_t w_next_state;

    // The bubble encoding is produced by the stage register; it must be an
    // OP-IMM (ADDI x0) so the shadow stage never sees a register write.
    if (NOP_INS[6:0] != 7'b0010011) begin : g_nop_check
        $error("NOP_INS must be an OP-IMM encoding");
    end

    function automatic logic [XLEN-1:0] f_sel(
        input logic [2:0]      code,
        input logic [XLEN-1:0] rf
    );
        case (code)
            3'd1:    f_sel = bus.mem_alu;
            3'd2:    f_sel = bus.wb_alu;
            3'd3:    f_sel = bus.wb_load;
            3'd4:    f_sel = r_tmp_load;
            3'd5:    f_sel = r_tmp_alu;
            default: f_sel = rf;
        endcase
    endfunction

    assign bus.rs1_fwd = f_sel(bus.forward_signal1, bus.rs1_rf);
    assign bus.rs2_fwd = f_sel(bus.forward_signal2, bus.rs2_rf);

    // MWAIT remembers whether the last honoured cycle was a stall so that a
    // memory wait does not break up a back-to-back stall pair.
    assign w_prev_stall = (r_state == ST_LSTALL) ||
                          ((r_state == ST_MWAIT) && r_wait_stall);
    assign w_stall_now  = bus.mem_ready && bus.stall;
    assign w_sel_err    = (bus.forward_signal1[2:1] == 2'b11) ||
                          (bus.forward_signal2[2:1] == 2'b11);

    always_comb begin
        w_pc_en         = 1'b0;
        w_if_id_en      = 1'b0;
        w_id_ex_en      = 1'b0;
        w_ex_mem_en     = 1'b0;
        w_mem_wb_en     = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_ex_mem_bubble = 1'b0;
        w_next_state    = ST_RUN;
        if (!bus.mem_ready) begin
            w_next_state = ST_MWAIT;
        end else if (bus.stall) begin
            w_next_state    = ST_LSTALL;
            w_ex_mem_en     = rstn;
            w_ex_mem_bubble = rstn;
            w_mem_wb_en     = rstn;
        end else begin
            w_pc_en       = rstn;
            w_if_id_en    = rstn;
            w_id_ex_en    = rstn;
            w_ex_mem_en   = rstn;
            w_mem_wb_en   = rstn;
            w_if_id_flush = rstn && bus.branch_taken;
            w_id_ex_flush = rstn && bus.branch_taken;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_RUN;
            r_wait_stall <= 1'b0;
            r_tmp_alu    <= '0;
            r_tmp_load   <= '0;
            r_temp_ins   <= '0;
            r_temp_dec   <= '0;
            r_stall_cnt  <= '0;
            r_hit_cnt    <= '0;
            r_fwd_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (!bus.mem_ready) begin
                r_wait_stall <= w_prev_stall;
            end
            if (w_mem_wb_en) begin
                r_temp_ins <= bus.WB_ins;
                r_temp_dec <= bus.WB_decode;
                r_tmp_alu  <= bus.wb_alu;
                r_tmp_load <= bus.wb_load;
            end
            if (w_stall_now && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (bus.mem_ready && bus.temp_wb && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_sel_err || (w_stall_now && w_prev_stall)) begin
                r_fwd_err <= 1'b1;
            end
        end
    end

    assign bus.pc_en          = w_pc_en;
    assign bus.if_id_en       = w_if_id_en;
    assign bus.id_ex_en       = w_id_ex_en;
    assign bus.ex_mem_en      = w_ex_mem_en;
    assign bus.mem_wb_en      = w_mem_wb_en;
    assign bus.if_id_flush    = w_if_id_flush;
    assign bus.id_ex_flush    = w_id_ex_flush;
    assign bus.ex_mem_bubble  = w_ex_mem_bubble;
    assign bus.WB_temp_ins    = r_temp_ins;
    assign bus.WB_temp_decode = r_temp_dec;
    assign bus.stall_cnt      = r_stall_cnt;
    assign bus.temp_hit_cnt   = r_hit_cnt;
    assign bus.fwd_err        = r_fwd_err;

endmodule

`default_nettype wire

// File: tb/tb_fwd_apply_ctrl.sv
// ============================================================================
// Module  : tb_fwd_apply_ctrl
// Brief   : Directed self-checking bench for fwd_apply_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fwd_apply_ctrl;
    localparam int c_XLEN  = 64;
    localparam int c_DEC_W = 22;

    logic r_clk;
    logic r_rstn;
    int   r_checks;
    int   r_errors;

    fwd_apply_ctrl_if #(.XLEN(c_XLEN), .DEC_W(c_DEC_W)) bus ();

    fwd_apply_ctrl #(
        .XLEN   (c_XLEN),
        .DEC_W  (c_DEC_W),
        .NOP_INS(32'h00000013)
    ) u_dut (
        .clk (r_clk),
        .rstn(r_rstn),
        .bus (bus)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {pc, if_id, id_ex, ex_mem, mem_wb}
    function automatic logic [4:0] f_en();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en};
    endfunction

    // {if_id_flush, id_ex_flush, ex_mem_bubble}
    function automatic logic [2:0] f_fl();
        return {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_bubble};
    endfunction

    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    initial begin
        r_checks = 0;
        r_errors = 0;
        bus.stall = 0; bus.temp_wb = 0; bus.forward_signal1 = 0; bus.forward_signal2 = 0;
        bus.branch_taken = 0; bus.mem_ready = 1;
        bus.rs1_rf = 64'h1111; bus.rs2_rf = 64'h2222; bus.mem_alu = 64'h3333;
        bus.wb_alu = 64'h4444; bus.wb_load = 64'h5555;
        bus.WB_ins = 32'h00A00513; bus.WB_decode = 22'h200000;
        r_rstn = 0;

        // Reset
        #12;
        check("rst_ins", {32'd0, bus.WB_temp_ins}, 64'd0);
        check("rst_dec", {42'd0, bus.WB_temp_decode}, 64'd0);
        check("rst_en", {59'd0, f_en()}, 64'd0);
        check("rst_fl", {61'd0, f_fl()}, 64'd0);
        check("rst_scnt", {32'd0, bus.stall_cnt}, 64'd0);
        check("rst_err", {63'd0, bus.fwd_err}, 64'd0);
        r_rstn = 1;
        step();
        check("cap_ins", {32'd0, bus.WB_temp_ins}, 64'h00A00513);
        check("cap_dec", {42'd0, bus.WB_temp_decode}, 64'h200000);
        check("run_en", {59'd0, f_en()}, 64'h1F);
        check("run_rs1", bus.rs1_fwd, 64'h1111);

        // Load-use stall
        bus.stall = 1; #1;
        check("lu_en", {59'd0, f_en()}, 64'h03);
        check("lu_fl", {61'd0, f_fl()}, 64'h1);
        step();
        check("lu_scnt", {32'd0, bus.stall_cnt}, 64'd1);
        bus.stall = 0; bus.forward_signal1 = 3; bus.wb_load = 64'hDEAD; #1;
        check("lu_rs1", bus.rs1_fwd, 64'hDEAD);
        check("lu_en2", {59'd0, f_en()}, 64'h1F);

        // Shadow capture then temp forwarding
        bus.forward_signal1 = 0; bus.wb_load = 64'h11; bus.wb_alu = 64'h22;
        step();
        bus.wb_load = 64'h99; bus.wb_alu = 64'h88;
        bus.forward_signal2 = 0; #1;
        check("mux_rf", bus.rs2_fwd, 64'h2222);
        bus.forward_signal2 = 1; #1;
        check("mux_mem", bus.rs2_fwd, 64'h3333);
        bus.forward_signal2 = 2; #1;
        check("mux_wb", bus.rs2_fwd, 64'h88);
        bus.forward_signal2 = 4; bus.temp_wb = 1; #1;
        check("tmp_load", bus.rs2_fwd, 64'h11);
        step();
        bus.wb_load = 64'h77; bus.wb_alu = 64'h66;
        bus.forward_signal2 = 5; #1;
        check("tmp_alu", bus.rs2_fwd, 64'h88);
        step();
        bus.temp_wb = 0; bus.forward_signal2 = 0; #1;
        check("hit_cnt", {32'd0, bus.temp_hit_cnt}, 64'd2);

        // Branch with stall, then branch alone
        bus.branch_taken = 1; bus.stall = 1; #1;
        check("bs_fl", {61'd0, f_fl()}, 64'h1);
        check("bs_en", {59'd0, f_en()}, 64'h03);
        step();
        check("bs_scnt", {32'd0, bus.stall_cnt}, 64'd2);
        bus.stall = 0; #1;
        check("br_fl", {61'd0, f_fl()}, 64'h6);
        check("br_en", {59'd0, f_en()}, 64'h1F);
        step();
        bus.branch_taken = 0;
        check("br_err", {63'd0, bus.fwd_err}, 64'd0);

        // Memory wait during a stall
        bus.WB_ins = 32'hCAFE0013; bus.stall = 1; bus.mem_ready = 0; #1;
        check("mw_en", {59'd0, f_en()}, 64'd0);
        check("mw_fl", {61'd0, f_fl()}, 64'd0);
        for (int i = 0; i < 3; i++) step();
        check("mw_ins", {32'd0, bus.WB_temp_ins}, 64'h00A00513);
        check("mw_scnt", {32'd0, bus.stall_cnt}, 64'd2);
        bus.mem_ready = 1; #1;
        check("mw_res_en", {59'd0, f_en()}, 64'h03);
        step();
        check("mw_res_scnt", {32'd0, bus.stall_cnt}, 64'd3);
        check("mw_res_ins", {32'd0, bus.WB_temp_ins}, 64'hCAFE0013);
        bus.stall = 0; #1;
        check("mw_err", {63'd0, bus.fwd_err}, 64'd0);
        check("mw_run_en", {59'd0, f_en()}, 64'h1F);

        // Illegal select code
        bus.forward_signal1 = 7; #1;
        check("e7_rs1", bus.rs1_fwd, 64'h1111);
        step();
        bus.forward_signal1 = 0;
        check("e7_err", {63'd0, bus.fwd_err}, 64'd1);
        step();
        check("e7_sticky", {63'd0, bus.fwd_err}, 64'd1);

        // Back-to-back stall after reset
        r_rstn = 0; #1;
        check("r2_err", {63'd0, bus.fwd_err}, 64'd0);
        check("r2_hit", {32'd0, bus.temp_hit_cnt}, 64'd0);
        r_rstn = 1;
        bus.stall = 1;
        step();
        check("s1_err", {63'd0, bus.fwd_err}, 64'd0);
        step();
        check("s2_err", {63'd0, bus.fwd_err}, 64'd1);
        check("s2_scnt", {32'd0, bus.stall_cnt}, 64'd2);
        bus.stall = 0;
        step();
        check("s2_sticky", {63'd0, bus.fwd_err}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
